// File: rtl/prbs_chk.sv
// rtl/prbs_chk.sv - self-synchronising x^8+x^4+x^3+x^2+1 serial PRBS checker
`timescale 1ns/1ps
module prbs_chk #(
  parameter int LOCK_CNT = 16,
  parameter int ERR_WIN  = 64,
  parameter int ERR_MAX  = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic             in_bit,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int WIN_W  = (ERR_WIN > 2) ? $clog2(ERR_WIN) : 1;
  localparam int WERR_W = $clog2(ERR_MAX + 1);

  typedef enum logic [1:0] {FILL, SEARCH, LOCKED} state_t;

  state_t            state;
  logic [7:0]        hist;
  logic [2:0]        fill_cnt;
  logic [RUN_W-1:0]  run;
  logic [WIN_W-1:0]  win_pos;
  logic [WERR_W-1:0] win_err;

  logic              pred;
  logic              match;
  logic [WERR_W-1:0] win_err_nxt;

  // hist[0] is the newest bit, so the taps realise s[n+8] = s[n+4]^s[n+3]^s[n+2]^s[n]
  always_comb begin
    pred        = hist[3] ^ hist[4] ^ hist[5] ^ hist[7];
    match       = (in_bit == pred);
    win_err_nxt = win_err + {{(WERR_W-1){1'b0}}, ~match};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL;
      hist     <= '0;
      fill_cnt <= '0;
      run      <= '0;
      win_pos  <= '0;
      win_err  <= '0;
      locked   <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= '0;
      bit_cnt  <= '0;
    end else begin
      err <= 1'b0;
      if (in_vld) begin
        case (state)
          FILL: begin
            hist <= {hist[6:0], in_bit};
            if (fill_cnt == 3'd7) begin
              state    <= SEARCH;
              fill_cnt <= '0;
              run      <= '0;
            end else begin
              fill_cnt <= fill_cnt + 3'd1;
            end
          end
          SEARCH: begin
            hist <= {hist[6:0], in_bit};
            // An all-zero history predicts zero forever; never let it count toward lock
            if (match && (hist != 8'h00)) begin
              if (run == RUN_W'(LOCK_CNT - 1)) begin
                state   <= LOCKED;
                locked  <= 1'b1;
                run     <= '0;
                win_pos <= '0;
                win_err <= '0;
              end else begin
                run <= run + RUN_W'(1);
              end
            end else begin
              run <= '0;
            end
          end
          LOCKED: begin
            // Flywheel on our own prediction so one line error is flagged once
            hist <= {hist[6:0], pred};
            if (!match) err <= 1'b1;
            if (win_err_nxt == WERR_W'(ERR_MAX)) begin
              state    <= FILL;
              locked   <= 1'b0;
              fill_cnt <= '0;
              win_pos  <= '0;
              win_err  <= '0;
            end else if (win_pos == WIN_W'(ERR_WIN - 1)) begin
              win_pos <= '0;
              win_err <= '0;
            end else begin
              win_pos <= win_pos + WIN_W'(1);
              win_err <= win_err_nxt;
            end
          end
          default: state <= FILL;
        endcase
      end

      if (clr) begin
        err_cnt <= '0;
        bit_cnt <= '0;
      end else if (in_vld && (state == LOCKED)) begin
        if (bit_cnt != '1) bit_cnt <= bit_cnt + CNT_W'(1);
        if (!match && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule
